// File: rtl/vtg_pkg.sv
// Shared timing constants, FSM state type and colour-bar table for the 720p timing generator.
// The optional colour-bar output of vtg_720p is enabled with the VTG_PATTERN_EN macro.
package vtg_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FRONT_720P  = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BACK_720P   = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FRONT_720P  = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BACK_720P   = 20;

  localparam int H_TOTAL_720P = H_ACTIVE_720P + H_FRONT_720P + H_SYNC_720P + H_BACK_720P;
  localparam int V_TOTAL_720P = V_ACTIVE_720P + V_FRONT_720P + V_SYNC_720P + V_BACK_720P;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RUN
  } vtg_state_e;

  // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/vtg_720p_lock_qualifier.sv
// Synchronizes the PLL lock and requires LOCK_STABLE consecutive locked cycles before
// timing generation may run; run_en is the next-cycle RUN indication for the counters.
module lock_qualifier
  import vtg_pkg::*;
#(
  parameter int LOCK_STABLE = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  output logic run_en,
  output logic running
);

  localparam int CNT_W = (LOCK_STABLE < 2) ? 1 : $clog2(LOCK_STABLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE - 1);

  if (LOCK_STABLE < 2) begin : g_bad_lock_stable
    $error("lock_qualifier: LOCK_STABLE must be at least 2");
  end

  logic             r_sync_p0;
  logic             r_sync_p1;
  vtg_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_running;
  logic             w_lock_s;

  assign w_lock_s = r_sync_p1;

  // stage p0 -> p1: two-flop synchronizer for the asynchronous lock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= pll_lock;
      r_sync_p1 <= r_sync_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= WAIT_LOCK;
      r_cnt     <= '0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_cnt     <= '0;
          r_running <= 1'b0;
          if (w_lock_s) r_state <= STABLE;
        end
        STABLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!w_lock_s) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= WAIT_LOCK;
          r_cnt     <= '0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // High when the state after this edge will be RUN, so the counters can align with it.
  assign run_en  = !reset && w_lock_s &&
                   ((r_state == RUN) || ((r_state == STABLE) && (r_cnt == CNT_LAST)));
  assign running = r_running;

endmodule

// File: rtl/vtg_720p.sv
// Video timing generator: free-running pixel/line counters with registered, aligned
// hsync/vsync/de decode. Define VTG_PATTERN_EN to add the 24-bit colour-bar rgb output.
module vtg_720p
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_720P,
  parameter int H_FRONT     = H_FRONT_720P,
  parameter int H_SYNC      = H_SYNC_720P,
  parameter int H_BACK      = H_BACK_720P,
  parameter int V_ACTIVE    = V_ACTIVE_720P,
  parameter int V_FRONT     = V_FRONT_720P,
  parameter int V_SYNC      = V_SYNC_720P,
  parameter int V_BACK      = V_BACK_720P,
  parameter int SYNC_POS    = 1,
  parameter int LOCK_STABLE = 1024,
  localparam int H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int CX_W       = $clog2(H_TOTAL),
  localparam int CY_W       = $clog2(V_TOTAL)
) (
  input  logic            clk_pixel,
  input  logic            reset,
  input  logic            pll_lock,
  output logic            running,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            line_start,
  output logic            frame_start
`ifdef VTG_PATTERN_EN
  ,
  output logic [23:0]     rgb
`endif
);

  if ((H_FRONT == 0) || (H_SYNC == 0) || (H_BACK == 0) ||
      (V_FRONT == 0) || (V_SYNC == 0) || (V_BACK == 0)) begin : g_bad_porch
    $error("vtg_720p: porch and sync widths must be non-zero");
  end

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(H_TOTAL - 1);
  localparam logic [CX_W-1:0] CX_ACT  = CX_W'(H_ACTIVE);
  localparam logic [CX_W-1:0] CX_HS0  = CX_W'(H_ACTIVE + H_FRONT);
  localparam logic [CX_W-1:0] CX_HS1  = CX_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(V_TOTAL - 1);
  localparam logic [CY_W-1:0] CY_ACT  = CY_W'(V_ACTIVE);
  localparam logic [CY_W-1:0] CY_VS0  = CY_W'(V_ACTIVE + V_FRONT);
  localparam logic [CY_W-1:0] CY_VS1  = CY_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic            SYNC_ACT = (SYNC_POS != 0);

  function automatic logic sync_level(input logic act);
    return act ? SYNC_ACT : ~SYNC_ACT;
  endfunction

  logic            w_run_en;
  logic            w_running;
  logic [CX_W-1:0] w_cx_nxt;
  logic [CY_W-1:0] w_cy_nxt;
  logic            w_de;
  logic            w_hs_act;
  logic            w_vs_act;
  logic            w_line_start;
  logic            w_frame_start;

  logic [CX_W-1:0] r_cx;
  logic [CY_W-1:0] r_cy;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_de;
  logic            r_line_start;
  logic            r_frame_start;

  lock_qualifier #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_qualifier (
    .clk      (clk_pixel),
    .reset    (reset),
    .pll_lock (pll_lock),
    .run_en   (w_run_en),
    .running  (w_running)
  );

  // Decode is done on the next counter values so every output lands with its cx/cy.
  always_comb begin
    w_cx_nxt = '0;
    w_cy_nxt = '0;
    if (w_run_en && w_running) begin
      if (r_cx == CX_LAST) begin
        w_cy_nxt = (r_cy == CY_LAST) ? '0 : r_cy + 1'b1;
      end else begin
        w_cx_nxt = r_cx + 1'b1;
        w_cy_nxt = r_cy;
      end
    end
  end

  assign w_de          = w_run_en && (w_cx_nxt < CX_ACT) && (w_cy_nxt < CY_ACT);
  assign w_hs_act      = w_run_en && (w_cx_nxt >= CX_HS0) && (w_cx_nxt < CX_HS1);
  assign w_vs_act      = w_run_en && (w_cy_nxt >= CY_VS0) && (w_cy_nxt < CY_VS1);
  assign w_line_start  = w_run_en && (w_cx_nxt == '0);
  assign w_frame_start = w_line_start && (w_cy_nxt == '0);

  // stage p0: registered counters and decoded timing
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_cx          <= '0;
      r_cy          <= '0;
      r_hsync       <= ~SYNC_ACT;
      r_vsync       <= ~SYNC_ACT;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_cx          <= w_cx_nxt;
      r_cy          <= w_cy_nxt;
      r_hsync       <= sync_level(w_hs_act);
      r_vsync       <= sync_level(w_vs_act);
      r_de          <= w_de;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
    end
  end

  assign running     = w_running;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign cx          = r_cx;
  assign cy          = r_cy;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VTG_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  w_bar_idx;
  logic [23:0] r_rgb;

  assign w_bar_idx = 3'(w_cx_nxt / CX_W'(BAR_W));

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_de ? BAR_RGB[w_bar_idx] : 24'h000000;
    end
  end

  assign rgb = r_rgb;
`endif

endmodule

// File: tb/tb_vtg_720p.sv
// Scoreboard bench for vtg_720p with reduced timing so whole frames fit in a short run.
module tb_vtg_720p;

  localparam int HA = 16, HF = 3, HSW = 4, HB = 5;
  localparam int VA = 6,  VF = 2, VSW = 2, VB = 3;
  localparam int LS = 16;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int CXW = $clog2(HT);
  localparam int CYW = $clog2(VT);
  localparam int OW = 6 + CXW + CYW + 24;

  typedef logic [OW-1:0] obs_t;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;
  logic pll_lock  = 1'b1;
  logic running, hsync, vsync, de, line_start, frame_start;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic [23:0] rgb_obs;

`ifdef VTG_PATTERN_EN
  logic [23:0] rgb;
  assign rgb_obs = rgb;
`else
  assign rgb_obs = 24'h0;
`endif

  vtg_720p #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB),
    .SYNC_POS (1), .LOCK_STABLE (LS)
  ) dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .running     (running),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .cx          (cx),
    .cy          (cy),
    .line_start  (line_start),
`ifdef VTG_PATTERN_EN
    .rgb         (rgb),
`endif
    .frame_start (frame_start)
  );

  always #5 clk_pixel = ~clk_pixel;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Reference model: lock seen two edges late, RUN after LS+1 consecutive locked edges,
  // then a linear pixel position within the frame.
  bit m_rs1 = 1, m_rs2 = 1, m_lk1 = 0, m_lk2 = 0, m_run = 0;
  int m_consec = 0, m_pos = 0;

  task automatic step(input bit rs, input bit lk);
    bit ls, e_de, e_hs, e_vs;
    int x, y;
    logic [23:0] col;
    reset    = rs;
    pll_lock = lk;
    ls = !m_rs1 && !m_rs2 && m_lk2;
    m_consec = ls ? m_consec + 1 : 0;
    if (!rs && m_consec >= LS + 1) begin
      m_pos = m_run ? (m_pos + 1) % FRAME : 0;
      m_run = 1;
    end else begin
      m_run = 0;
      m_pos = 0;
    end
    m_rs2 = m_rs1; m_rs1 = rs;
    m_lk2 = m_lk1; m_lk1 = lk;
    x = m_pos % HT;
    y = m_pos / HT;
    e_de = m_run && x < HA && y < VA;
    e_hs = m_run && x >= HA + HF && x < HA + HF + HSW;
    e_vs = m_run && y >= VA + VF && y < VA + VF + VSW;
    col  = 24'h0;
`ifdef VTG_PATTERN_EN
    if (e_de) col = bar_colour(x / (HA / 8));
`endif
    exp_q.push_back({m_run, e_hs, e_vs, e_de, m_run && x == 0, m_run && m_pos == 0,
                     CXW'(x), CYW'(y), col});
    @(negedge clk_pixel);
  endtask

  // Scoreboard monitor
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk_pixel);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {running, hsync, vsync, de, line_start, frame_start, cx, cy, rgb_obs};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL scoreboard cyc=%0d got run/hs/vs/de/ls/fs=%b cx=%0d cy=%0d rgb=%h required %b cx=%0d cy=%0d rgb=%h",
                      cyc, a[OW-1 -: 6], a[CXW+CYW+23 -: CXW], a[CYW+23 -: CYW], a[23:0],
                      e[OW-1 -: 6], e[CXW+CYW+23 -: CXW], e[CYW+23 -: CYW], e[23:0]);
      end
    end
  end

  // Directed measurements: RUN entry latency and per-frame totals
  bit lat_done = 0, frame_done = 0, in_frame = 0, prev_run = 0;
  int rel_cnt = 0, f_cyc = 0, f_de = 0, f_hs = 0, f_vs = 0;
  initial begin
    forever begin
      @(posedge clk_pixel);
      #2;
      rel_cnt = reset ? 0 : rel_cnt + 1;
      if (running && !prev_run && !lat_done) begin
        chk("run_latency", rel_cnt, LS + 3);
        chk("first_run_cx_cy_fs_de", {28'd0, cx == 0, cy == 0, frame_start, de}, 15);
        lat_done = 1;
      end
      if (!running) begin
        in_frame = 0;
      end else if (frame_start) begin
        if (in_frame && !frame_done) begin
          chk("frame_period", f_cyc, FRAME);
          chk("de_cycles", f_de, HA * VA);
          chk("hsync_cycles", f_hs, HSW * VT);
          chk("vsync_cycles", f_vs, VSW * HT);
          frame_done = 1;
        end
        in_frame = 1;
        f_cyc = 0; f_de = 0; f_hs = 0; f_vs = 0;
      end
      if (running && in_frame) begin
        f_cyc++;
        f_de += int'(de);
        f_hs += int'(hsync);
        f_vs += int'(vsync);
      end
      prev_run = running;
    end
  end

  // Stimulus
  initial begin
    int hi, lo;
    repeat (5) step(1, 1);
    repeat (LS + 3 + 2 * FRAME + 5) step(0, 1);
    // lock lost while running, then a one-cycle glitch during qualification
    repeat (3) step(0, 0);
    repeat (13) step(0, 1);
    step(0, 0);
    repeat (LS + 3 + FRAME + 10) step(0, 1);
    for (int b = 0; b < 40; b++) begin
      hi = ($urandom_range(0, 2) == 0) ? int'($urandom_range(380, 800)) : int'($urandom_range(1, 40));
      repeat (hi) step(0, 1);
      lo = int'($urandom_range(1, 4));
      repeat (lo) step(0, 0);
      if ($urandom_range(0, 9) == 0) repeat (2) step(1, 1'($urandom_range(0, 1)));
    end
    repeat (LS + 3 + 40) step(0, 1);
    @(negedge clk_pixel);
    if (!lat_done) chk("run_latency_reached", 0, 1);
    if (!frame_done) chk("full_frame_reached", 0, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vtg_720p.md
Name: vtg_720p

Overview:
- Video timing generator in the pixel clock domain, directly downstream of the HDMI rPLL and its clock divider.
- Qualifies the PLL lock, then free-runs horizontal and vertical counters.
- Produces hsync, vsync and data-enable (de), plus the pixel coordinates consumed by the TIA pixel fetch and the TMDS encoder.
- Defaults are CEA-861 1280x720p60 at 74.25 MHz.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FRONT, 110, horizontal front porch in pixels
- H_SYNC, 40, hsync width in pixels
- H_BACK, 220, horizontal back porch in pixels
- V_ACTIVE, 720, active lines per frame
- V_FRONT, 5, vertical front porch in lines
- V_SYNC, 5, vsync width in lines
- V_BACK, 20, vertical back porch in lines
- SYNC_POS, 1, 1 = active-high syncs, 0 = active-low
- LOCK_STABLE, 1024, consecutive synchronized-lock cycles required before running

Ports:
- clk_pixel  in  1  pixel clock (74.25 MHz); the only clock
- reset  in  1  synchronous, active-high reset
- pll_lock  in  1  PLL lock; asynchronous to clk_pixel
- running  out  1  high while timing is being generated
- hsync  out  1  horizontal sync, polarity set by SYNC_POS
- vsync  out  1  vertical sync, polarity set by SYNC_POS
- de  out  1  high during active pixels
- cx  out  CX_W  horizontal counter; CX_W = $clog2(H_TOTAL), 11 by default
- cy  out  CY_W  vertical counter; CY_W = $clog2(V_TOTAL), 10 by default
- line_start  out  1  one-cycle pulse at cx == 0
- frame_start  out  1  one-cycle pulse at cx == 0, cy == 0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK (1650); V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK (750).
- Lock input: pll_lock passes through a 2-flop synchronizer; lock_s is the synchronized output.
- Reset:
  - clears synchronizer flops, stable counter, cx and cy;
  - state = WAIT_LOCK;
  - running = 0, de = 0, line_start = 0, frame_start = 0;
  - hsync/vsync held at inactive level (!SYNC_POS).
- FSM:
  - WAIT_LOCK: stable counter held at 0. When lock_s = 1, go to STABLE.
  - STABLE: counter increments each cycle while lock_s = 1. lock_s = 0 returns to WAIT_LOCK and clears the counter. When the counter reaches LOCK_STABLE-1, go to RUN with cx = cy = 0.
  - RUN: timing is generated. lock_s = 0 returns to WAIT_LOCK on the next edge; all outputs return to reset values in that same cycle.
- Counters in RUN:
  - cx increments each cycle and wraps H_TOTAL-1 -> 0.
  - cy increments when cx wraps and wraps V_TOTAL-1 -> 0.
  - Both wraps happen on the same edge at the frame end (1649, 749) -> (0, 0).
- Output decode, with column and line numbers counted from 0 at the start of active video:
  - de = (cx < H_ACTIVE) && (cy < V_ACTIVE).
  - hsync active for H_ACTIVE+H_FRONT <= cx < H_ACTIVE+H_FRONT+H_SYNC (columns 1390..1429).
  - vsync active for V_ACTIVE+V_FRONT <= cy < V_ACTIVE+V_FRONT+V_SYNC (lines 725..729), whole lines, changing at cx == 0.
- Registration and alignment:
  - All outputs are registered and aligned: hsync, vsync, de, line_start and frame_start correspond to the cx/cy presented in the same cycle.
  - Latency from the RUN entry edge to first frame_start is 1 cycle: first RUN cycle shows cx = 0, cy = 0, frame_start = 1, de = 1.
- running = 1 exactly in RUN.
- Elaboration checks:
  - elaboration error if any porch or sync parameter is 0;
  - elaboration error if LOCK_STABLE < 2.

Optional Feature:
- Macro: VTG_PATTERN_EN.
- When defined:
  - adds output rgb, 24 bits, registered and aligned with de;
  - pattern is 8 vertical colour bars, bar index = cx / (H_ACTIVE/8), 160 px each at defaults;
  - bar order: white, yellow, cyan, green, magenta, red, blue, black, each component 8'hFF or 8'h00;
  - rgb = 0 whenever de = 0 and in reset.
- When not defined: the rgb port is absent, with no extra logic.

Decomposition:
- Package vtg_pkg:
  - 720p timing constants;
  - derived H_TOTAL and V_TOTAL;
  - typedef of the FSM state enum {WAIT_LOCK, STABLE, RUN};
  - colour-bar constant array.
- Sub-module lock_qualifier:
  - contains the 2-flop synchronizer, the stable counter and the WAIT_LOCK/STABLE/RUN FSM;
  - output run_en feeds the counter/decode logic in vtg_720p.

Test Plan:
- Hold reset 5 cycles with pll_lock = 1 -> hsync = vsync = 0 (SYNC_POS = 1), de = 0, running = 0 throughout.
- Release reset, pll_lock = 1 constant, LOCK_STABLE = 16 -> running rises exactly 2 + 16 cycles after release, plus the 1-cycle RUN entry edge; first RUN cycle shows cx = 0, cy = 0, frame_start = 1, de = 1.
- Run one full frame -> 1,237,500 cycles between frame_start pulses.
- Same frame -> de high for exactly 921,600 cycles; hsync is 40 cycles at cx 1390..1429 on every line; vsync high for lines 725..729, i.e. 8250 cycles.
- Lock glitch: in STABLE drop pll_lock for 1 cycle at count 10 -> counter restarts from 0 and RUN entry is delayed accordingly. In RUN drop pll_lock -> running = 0 and syncs inactive 3 cycles later (2 sync + 1); timing restarts at (0, 0) after re-qualification.
- With VTG_PATTERN_EN, line 0 -> rgb = FFFFFF for cx 0..159, FFFF00 at cx 160, 000000 at cx 1279, 0 at cx 1280..1649.
